// File: rtl/ifetch_unit_if.sv
// Instruction-memory fetch bus: valid/ready request, response-valid return.
interface ifetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  ReqValid;
  logic [ADDR_WIDTH-1:0] ReqAddr;
  logic                  ReqReady;
  logic                  RespValid;
  logic [31:0]           RespData;

  modport master (
    output ReqValid,
    output ReqAddr,
    input  ReqReady,
    input  RespValid,
    input  RespData
  );

  modport slave (
    input  ReqValid,
    input  ReqAddr,
    output ReqReady,
    output RespValid,
    output RespData
  );
endinterface

// File: rtl/ifetch_unit.sv
// Single-outstanding instruction fetch unit with branch redirect and flush.
// Optional IFETCH_MISALIGN_TRAP_EN: misaligned redirects trap instead of being aligned.
module ifetch_unit #(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  ifetch_unit_if.master         imem,
  output logic [31:0]           Instr,
  output logic                  InstrValid,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic [ADDR_WIDTH-1:0] PCPlus4,
  input  logic                  Advance,
  input  logic                  PCSrc,
  input  logic [ADDR_WIDTH-1:0] PCTarget,
  input  logic                  Flush,
  input  logic [ADDR_WIDTH-1:0] FlushPC,
  output logic                  MisalignErr
);

`ifdef IFETCH_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  localparam logic [31:0] NopInstr = 32'h0000_0013;

  typedef enum logic [1:0] {StReq, StWait, StHold, StDrop} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]           instr_q, instr_d;
  logic                  ivalid_q, ivalid_d;
  logic                  err_q, err_d;
  logic                  req_valid_q;
  logic                  redir;
  logic [ADDR_WIDTH-1:0] redir_addr;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    ivalid_d   = ivalid_q;
    err_d      = err_q;
    redir      = 1'b0;
    redir_addr = pc_q;
    case (state_q)
      StReq: begin
        if (imem.ReqReady) state_d = StWait;
        if (Flush) begin
          redir      = 1'b1;
          redir_addr = FlushPC;
          // An accepted old address still owes us a response that must be dropped.
          state_d    = imem.ReqReady ? StDrop : StReq;
        end
      end
      StWait: begin
        if (Flush) begin
          redir      = 1'b1;
          redir_addr = FlushPC;
          state_d    = imem.RespValid ? StReq : StDrop;
        end else if (imem.RespValid) begin
          instr_d  = imem.RespData;
          ivalid_d = 1'b1;
          state_d  = StHold;
        end
      end
      StDrop: begin
        if (Flush) begin
          redir      = 1'b1;
          redir_addr = FlushPC;
          state_d    = imem.RespValid ? StReq : StDrop;
        end else if (imem.RespValid) begin
          state_d = StReq;
        end
      end
      StHold: begin
        if (Flush) begin
          redir      = 1'b1;
          redir_addr = FlushPC;
          ivalid_d   = 1'b0;
          state_d    = StReq;
        end else if (Advance && ivalid_q) begin
          ivalid_d = 1'b0;
          state_d  = StReq;
          if (PCSrc) begin
            redir      = 1'b1;
            redir_addr = PCTarget;
          end else begin
            pc_d = pc_q + ADDR_WIDTH'(4);
          end
        end
      end
      default: state_d = StReq;
    endcase

    if (redir) begin
      if (TrapEn) begin
        pc_d = redir_addr;
        // Park in hold with no valid word; only an aligned flush or reset restarts fetch.
        if (redir_addr[1:0] != 2'b00) begin
          err_d    = 1'b1;
          ivalid_d = 1'b0;
          state_d  = StHold;
        end
      end else begin
        pc_d = redir_addr & ~ADDR_WIDTH'(3);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StReq;
      pc_q        <= RESET_VECTOR;
      instr_q     <= NopInstr;
      ivalid_q    <= 1'b0;
      err_q       <= 1'b0;
      req_valid_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      ivalid_q    <= ivalid_d;
      err_q       <= err_d;
      req_valid_q <= (state_d == StReq);
    end
  end

  assign imem.ReqValid = req_valid_q;
  assign imem.ReqAddr  = pc_q;
  assign Instr         = instr_q;
  assign InstrValid    = ivalid_q;
  assign PC            = pc_q;
  assign PCPlus4       = pc_q + ADDR_WIDTH'(4);
  assign MisalignErr   = TrapEn ? err_q : 1'b0;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: memory responder, scoreboard of expected fetched words.
module tb_ifetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] Instr;
  logic        InstrValid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        Advance;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        Flush;
  logic [31:0] FlushPC;
  logic        MisalignErr;

  ifetch_unit_if #(.ADDR_WIDTH(32)) bus ();

  ifetch_unit #(
    .ADDR_WIDTH  (32),
    .RESET_VECTOR(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem       (bus),
    .Instr      (Instr),
    .InstrValid (InstrValid),
    .PC         (PC),
    .PCPlus4    (PCPlus4),
    .Advance    (Advance),
    .PCSrc      (PCSrc),
    .PCTarget   (PCTarget),
    .Flush      (Flush),
    .FlushPC    (FlushPC),
    .MisalignErr(MisalignErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          mem_lat = 1;
  bit          force_dead = 1'b0;
  bit          pending = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[23:0], 8'h13};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; also plays the instruction memory around the edge.
  task automatic tick();
    logic        acc;
    logic        fire;
    logic [31:0] a;
    acc  = bus.ReqValid && bus.ReqReady;
    a    = bus.ReqAddr;
    fire = bus.RespValid;
    @(posedge clk);
    #1;
    if (fire) begin
      bus.RespValid = 1'b0;
      pending       = 1'b0;
    end
    if (acc) begin
      pending = 1'b1;
      cnt     = mem_lat;
      paddr   = a;
    end
    if (pending && !bus.RespValid) begin
      if (cnt <= 1) begin
        bus.RespValid = 1'b1;
        bus.RespData  = force_dead ? 32'hDEAD_BEEF : mem_word(paddr);
      end else begin
        cnt--;
      end
    end
  endtask

  task automatic expect_fetch(input logic [31:0] a);
    exp_t e;
    e.pc    = a;
    e.instr = mem_word(a);
    sb.push_back(e);
  endtask

  task automatic wait_instr(input string tag, input int exp_cyc);
    int   cyc;
    exp_t e;
    cyc = 0;
    while (!InstrValid && cyc < 20) begin
      tick();
      cyc++;
    end
    if (!InstrValid) begin
      check({tag, "_timeout"}, {31'b0, InstrValid}, 32'h1);
    end else if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'h1);
    end else begin
      e = sb.pop_front();
      check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
      check({tag, "_instr"}, Instr, e.instr);
      check({tag, "_pc"}, PC, e.pc);
      check({tag, "_pcplus4"}, PCPlus4, e.pc + 32'h4);
    end
  endtask

  task automatic consume(input logic src, input logic [31:0] tgt);
    Advance  = 1'b1;
    PCSrc    = src;
    PCTarget = tgt;
    tick();
    Advance  = 1'b0;
    PCSrc    = 1'b0;
  endtask

  task automatic do_flush(input logic [31:0] tgt);
    Flush   = 1'b1;
    FlushPC = tgt;
    tick();
    Flush   = 1'b0;
  endtask

  initial begin
    int  k;
    bit  saw_ivalid;
    reset         = 1'b1;
    Advance       = 1'b0;
    PCSrc         = 1'b0;
    PCTarget      = '0;
    Flush         = 1'b0;
    FlushPC       = '0;
    bus.ReqReady  = 1'b1;
    bus.RespValid = 1'b0;
    bus.RespData  = '0;
    tick();
    tick();
    check("rst_ivalid", {31'b0, InstrValid}, 32'h0);
    check("rst_instr", Instr, 32'h0000_0013);
    check("rst_pc", PC, 32'h0);
    check("rst_err", {31'b0, MisalignErr}, 32'h0);
    reset = 1'b0;

    // First fetch and sequential stream
    check("first_reqvalid", {31'b0, bus.ReqValid}, 32'h1);
    check("first_reqaddr", bus.ReqAddr, 32'h0);
    expect_fetch(32'h0);
    wait_instr("f0", 2);
    consume(1'b0, '0);
    check("seq_addr4", bus.ReqAddr, 32'h4);
    expect_fetch(32'h4);
    wait_instr("f4", 2);
    consume(1'b0, '0);
    check("seq_addr8", bus.ReqAddr, 32'h8);
    expect_fetch(32'h8);
    wait_instr("f8", 2);

    // Taken branch
    consume(1'b1, 32'h40);
    check("br_reqaddr", bus.ReqAddr, 32'h40);
    check("br_reqvalid", {31'b0, bus.ReqValid}, 32'h1);
    expect_fetch(32'h40);
    wait_instr("f40", 2);

    // Flush while waiting; the late response must be dropped
    consume(1'b0, '0);
    mem_lat = 3;
    tick();
    force_dead = 1'b1;
    do_flush(32'h100);
    check("drop_reqvalid", {31'b0, bus.ReqValid}, 32'h0);
    check("drop_pc", bus.ReqAddr, 32'h100);
    saw_ivalid = 1'b0;
    k = 0;
    while (!bus.ReqValid && k < 10) begin
      tick();
      if (InstrValid) saw_ivalid = 1'b1;
      k++;
    end
    check("drop_no_ivalid", {31'b0, saw_ivalid}, 32'h0);
    check("drop_resume_valid", {31'b0, bus.ReqValid}, 32'h1);
    check("drop_resume_addr", bus.ReqAddr, 32'h100);
    force_dead = 1'b0;
    mem_lat    = 1;
    expect_fetch(32'h100);
    wait_instr("f100", 2);

    // Reset in hold with Advance; memory stalls afterwards
    reset   = 1'b1;
    Advance = 1'b1;
    tick();
    reset        = 1'b0;
    Advance      = 1'b0;
    bus.ReqReady = 1'b0;
    check("rst2_ivalid", {31'b0, InstrValid}, 32'h0);
    check("rst2_instr", Instr, 32'h0000_0013);
    for (int i = 0; i < 4; i++) begin
      check("stall_reqvalid", {31'b0, bus.ReqValid}, 32'h1);
      check("stall_reqaddr", bus.ReqAddr, 32'h0);
      tick();
    end
    bus.ReqReady = 1'b1;
    expect_fetch(32'h0);
    wait_instr("f0b", 2);

    // Top of address space: PC+4 wraps
    do_flush(32'hFFFF_FFFC);
    check("wrap_reqaddr", bus.ReqAddr, 32'hFFFF_FFFC);
    expect_fetch(32'hFFFF_FFFC);
    wait_instr("ftop", 2);
    consume(1'b0, '0);
    check("wrap_next", bus.ReqAddr, 32'h0);
    expect_fetch(32'h0);
    wait_instr("f0c", 2);

`ifdef IFETCH_MISALIGN_TRAP_EN
    consume(1'b1, 32'h42);
    check("trap_err", {31'b0, MisalignErr}, 32'h1);
    check("trap_pc", PC, 32'h42);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("trap_noreq", {31'b0, bus.ReqValid}, 32'h0);
      check("trap_noivalid", {31'b0, InstrValid}, 32'h0);
    end
    do_flush(32'h80);
    check("trap_resume_addr", bus.ReqAddr, 32'h80);
    check("trap_resume_valid", {31'b0, bus.ReqValid}, 32'h1);
    check("trap_err_sticky", {31'b0, MisalignErr}, 32'h1);
    expect_fetch(32'h80);
    wait_instr("f80", 2);
    check("trap_err_sticky2", {31'b0, MisalignErr}, 32'h1);
`else
    consume(1'b1, 32'h42);
    check("align_br_addr", bus.ReqAddr, 32'h40);
    check("align_br_err", {31'b0, MisalignErr}, 32'h0);
    expect_fetch(32'h40);
    wait_instr("f40b", 2);
    do_flush(32'h103);
    check("align_fl_addr", bus.ReqAddr, 32'h100);
    expect_fetch(32'h100);
    wait_instr("f100b", 2);
    check("align_fl_err", {31'b0, MisalignErr}, 32'h0);
`endif

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch front end that feeds the single-cycle controller and datapath. Maintains the PC and issues one-outstanding-request fetches to instruction memory over a valid/ready request and response-valid interface.
- Holds the fetched word until the core accepts it. Applies the branch redirect (PCSrc/PCTarget) produced by the controller path, plus an external flush.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value fetched first after reset.
- ADDR_WIDTH, 32, width of PC and memory address; arithmetic wraps modulo 2^ADDR_WIDTH.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- ReqValid  out  1  fetch request valid to instruction memory
- ReqAddr  out  ADDR_WIDTH  fetch address (always current PC)
- ReqReady  in  1  memory accepts request this cycle
- RespValid  in  1  instruction word valid (at least 1 cycle after acceptance)
- RespData  in  32  instruction word
- Instr  out  32  held instruction to decode (op = Instr[6:0], funct3 = Instr[14:12], funct7b5 = Instr[30])
- InstrValid  out  1  Instr/PC/PCPlus4 valid
- PC  out  ADDR_WIDTH  address of Instr
- PCPlus4  out  ADDR_WIDTH  PC + 4
- Advance  in  1  core consumes Instr this cycle (ignored unless InstrValid)
- PCSrc  in  1  taken redirect for the instruction being consumed
- PCTarget  in  ADDR_WIDTH  redirect target when PCSrc
- Flush  in  1  external redirect, any cycle
- FlushPC  in  ADDR_WIDTH  flush target
- MisalignErr  out  1  sticky misaligned-target flag (optional feature only; tied 0 otherwise)

Behaviour:
- States: S_REQ, S_WAIT, S_HOLD, S_DROP. Encoding is free.
- Reset (synchronous, clk edge with reset=1):
  - state=S_REQ, PC=RESET_VECTOR, Instr=32'h0000_0013 (NOP), InstrValid=0, MisalignErr=0.
  - Reset overrides all other inputs, including mid-transaction; a response arriving after reset is still consumed as a drop only if the state is S_DROP, otherwise ignored.
  - First ReqValid=1 in the first cycle after reset deasserts, with ReqAddr=RESET_VECTOR.
- ReqValid=1 only in S_REQ; ReqAddr=PC in all states.
- S_REQ:
  - ReqReady=1 -> S_WAIT.
  - Flush=1 -> PC<=FlushPC. If ReqReady was also 1 (old address accepted) -> S_DROP, else stay S_REQ.
  - An address change while unaccepted is legal per the imem contract.
- S_WAIT:
  - RespValid=1 -> Instr<=RespData, InstrValid<=1, S_HOLD. InstrValid rises the cycle after RespValid.
  - Flush=1 -> PC<=FlushPC. If RespValid is in the same cycle, discard the data and go to S_REQ; else go to S_DROP.
- S_DROP: ignore RespData. RespValid=1 -> S_REQ (Flush again: PC<=FlushPC, stay S_DROP).
- S_HOLD: outputs stable while Advance=0.
  - Advance=1: InstrValid<=0, PC<=(PCSrc ? PCTarget : PC+4), S_REQ. ReqValid for the next PC appears the next cycle.
  - Flush=1 (with or without Advance): Flush wins, PC<=FlushPC, InstrValid<=0, S_REQ.
- Priority everywhere: reset > Flush > PCSrc > sequential.
- PCPlus4 is combinational PC+4. PC+4 from the top of the address space wraps to 0.
- Throughput: minimum 3 cycles per instruction with 0-wait memory (REQ, WAIT, HOLD). No prefetch.
- RespValid in S_REQ or S_HOLD is a protocol violation and is ignored.

Optional Feature:
- IFETCH_MISALIGN_TRAP_EN defined:
  - A redirect (PCTarget or FlushPC) with addr[1:0]!=0 sets MisalignErr (sticky until reset).
  - PC still loads the target; the unit enters S_HOLD with InstrValid=0 and issues no further requests.
  - Only Flush with an aligned FlushPC or reset resumes fetching. Flush clears nothing; only reset clears MisalignErr.
- Not defined: target low two bits are forced to 0 before loading PC; MisalignErr tied 0.

Test Plan:
- Reset release, memory ready=1, response 1 cycle after acceptance returning 32'h0050_0093 -> ReqAddr=0 first cycle, InstrValid=1 two cycles later with Instr=32'h0050_0093, PC=0, PCPlus4=4.
- Three sequential fetches with Advance asserted on each InstrValid, PCSrc=0 -> ReqAddr sequence 0, 4, 8; 3 cycles per instruction.
- Advance with PCSrc=1, PCTarget=32'h0000_0040 -> next ReqAddr=32'h40, PC=32'h40 on the next InstrValid.
- Flush with FlushPC=32'h100 while in S_WAIT, response arriving 2 cycles later with 32'hDEAD_BEEF -> word dropped, InstrValid stays 0, next ReqAddr=32'h100.
- Reset asserted during S_HOLD with Advance=1 -> InstrValid=0, ReqAddr=RESET_VECTOR the cycle after reset deasserts; with ReqReady=0 held for 4 cycles -> ReqValid and ReqAddr stay constant.
- With IFETCH_MISALIGN_TRAP_EN, PCTarget=32'h42 -> MisalignErr=1, no ReqValid. Then Flush with FlushPC=32'h80 -> fetching resumes at 32'h80 and MisalignErr stays 1.
